// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EXE-stage forwarding / hazard unit.
package fwd_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             wb_en;
      logic             mem_read;
   } stage_rec_t;

   typedef struct packed {
      stage_rec_t       rec;
      logic [REG_W-1:0] src1;
      logic [REG_W-1:0] src2;
      logic             use1;
      logic             use2;
      logic             use3;
   } exe_rec_t;

   // Source operand reads a register that a pending writer targets; r0 never matches.
   function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                    input logic             src_used,
                                    input logic [REG_W-1:0] dest);
      return src_used && (src == dest) && (src != '0);
   endfunction

endpackage

// File: rtl/fwd_src_select.sv
// One EXE operand's forwarding select, resolved against the MEM and WB records.
module fwd_src_select
   import fwd_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             src_used,
   input  stage_rec_t       mem_rec,
   input  stage_rec_t       wb_rec,
   output logic [1:0]       sel,
   output logic             mem_load_hit
);

   logic mem_hit;
   logic wb_hit;
   logic unused_wb_mem_read;

   assign unused_wb_mem_read = wb_rec.mem_read;

   // MEM holds the younger result, so it wins over WB when both write the register
   always_comb begin
      mem_hit      = mem_rec.valid & mem_rec.wb_en & reg_hit(src, src_used, mem_rec.dest);
      wb_hit       = wb_rec.valid  & wb_rec.wb_en  & reg_hit(src, src_used, wb_rec.dest);
      sel          = FWD_REG;
      if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
      mem_load_hit = mem_hit & mem_rec.mem_read;
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Tracks destination registers of in-flight instructions (EXE/MEM/WB), drives
// the EXE operand forwarding selects and the IF/ID load-use stall.
// Build option: FORWARDING_EN. When undefined, selects are tied to the register
// file path and any pending EXE/MEM writer of an ID source stalls instead.
module forwarding_hazard_unit
   import fwd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_use_src1,
   input  logic             id_use_src2,
   input  logic             id_use_src3,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_read,
   input  logic             flush,
   output logic [1:0]       val1_forward_sel,
   output logic [1:0]       val2_forward_sel,
   output logic [1:0]       val3_forward_sel,
   output logic             hazard_stall
);

   exe_rec_t   exe_q, exe_d;
   stage_rec_t mem_q, mem_d;
   stage_rec_t wb_q,  wb_d;
   logic       hazard;
   logic       hit_exe;

   // ID source versus pending destinations; src2 is read for register operands and store/branch data
`ifdef FORWARDING_EN
   always_comb begin
      hit_exe = reg_hit(id_src1, id_use_src1, exe_q.rec.dest) |
                reg_hit(id_src2, id_use_src2 | id_use_src3, exe_q.rec.dest);
      hazard  = exe_q.rec.valid & exe_q.rec.mem_read & exe_q.rec.wb_en & hit_exe;
   end
`else
   logic hit_mem;

   always_comb begin
      hit_exe = reg_hit(id_src1, id_use_src1, exe_q.rec.dest) |
                reg_hit(id_src2, id_use_src2 | id_use_src3, exe_q.rec.dest);
      hit_mem = reg_hit(id_src1, id_use_src1, mem_q.dest) |
                reg_hit(id_src2, id_use_src2 | id_use_src3, mem_q.dest);
      hazard  = (exe_q.rec.valid & exe_q.rec.wb_en & hit_exe) |
                (mem_q.valid     & mem_q.wb_en     & hit_mem);
   end
`endif

   // A taken branch discards the ID instruction, so it overrides the stall
   assign hazard_stall = hazard & ~flush;

   // Pipeline advance: stall or flush put a bubble into EXE
   always_comb begin
      exe_d.rec.valid    = ~(hazard | flush);
      exe_d.rec.dest     = id_dest;
      exe_d.rec.wb_en    = id_wb_en;
      exe_d.rec.mem_read = id_mem_read;
      exe_d.src1         = id_src1;
      exe_d.src2         = id_src2;
      exe_d.use1         = id_use_src1;
      exe_d.use2         = id_use_src2;
      exe_d.use3         = id_use_src3;
      mem_d              = exe_q.rec;
      wb_d               = mem_q;
   end

   // Stage record registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exe_q <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         exe_q <= exe_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

`ifdef FORWARDING_EN
   logic [2:0] load_hit;

   fwd_src_select u_sel_val1 (
      .src          (exe_q.src1),
      .src_used     (exe_q.use1 & exe_q.rec.valid),
      .mem_rec      (mem_q),
      .wb_rec       (wb_q),
      .sel          (val1_forward_sel),
      .mem_load_hit (load_hit[0])
   );

   fwd_src_select u_sel_val2 (
      .src          (exe_q.src2),
      .src_used     (exe_q.use2 & exe_q.rec.valid),
      .mem_rec      (mem_q),
      .wb_rec       (wb_q),
      .sel          (val2_forward_sel),
      .mem_load_hit (load_hit[1])
   );

   fwd_src_select u_sel_val3 (
      .src          (exe_q.src2),
      .src_used     (exe_q.use3 & exe_q.rec.valid),
      .mem_rec      (mem_q),
      .wb_rec       (wb_q),
      .sel          (val3_forward_sel),
      .mem_load_hit (load_hit[2])
   );

   // The load-use stall guarantees a load is never forwarded from MEM
   a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (!rst_n) load_hit == 3'b000);
`else
   logic unused_fwd_fields;

   assign val1_forward_sel  = FWD_REG;
   assign val2_forward_sel  = FWD_REG;
   assign val3_forward_sel  = FWD_REG;
   assign unused_fwd_fields = ^{exe_q.src1, exe_q.src2, exe_q.use1, exe_q.use2, exe_q.use3, wb_q};
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit; expectations follow FORWARDING_EN.
module tb_forwarding_hazard_unit;

`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_src1, id_src2, id_dest;
   logic       id_use_src1, id_use_src2, id_use_src3;
   logic       id_wb_en, id_mem_read, flush;
   logic [1:0] val1_forward_sel, val2_forward_sel, val3_forward_sel;
   logic       hazard_stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   forwarding_hazard_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .id_src1          (id_src1),
      .id_src2          (id_src2),
      .id_use_src1      (id_use_src1),
      .id_use_src2      (id_use_src2),
      .id_use_src3      (id_use_src3),
      .id_dest          (id_dest),
      .id_wb_en         (id_wb_en),
      .id_mem_read      (id_mem_read),
      .flush            (flush),
      .val1_forward_sel (val1_forward_sel),
      .val2_forward_sel (val2_forward_sel),
      .val3_forward_sel (val3_forward_sel),
      .hazard_stall     (hazard_stall)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic [4:0] s1, input logic [4:0] s2,
                           input logic u1, input logic u2, input logic u3,
                           input logic [4:0] d, input logic wb, input logic mr);
      id_src1     = s1;
      id_src2     = s2;
      id_use_src1 = u1;
      id_use_src2 = u2;
      id_use_src3 = u3;
      id_dest     = d;
      id_wb_en    = wb;
      id_mem_read = mr;
   endtask

   task automatic nop_id();
      drive_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      nop_id();
      flush = 1'b0;
      repeat (3) tick();
   endtask

   // Holds the instruction in ID while stalled (bounded), then moves it into EXE
   task automatic issue(input logic [4:0] s1, input logic [4:0] s2,
                        input logic u1, input logic u2, input logic u3,
                        input logic [4:0] d, input logic wb, input logic mr,
                        output int stalls);
      drive_id(s1, s2, u1, u2, u3, d, wb, mr);
      #1;
      stalls = 0;
      while (hazard_stall && stalls < 4) begin
         stalls++;
         tick();
      end
      tick();
      nop_id();
      #1;
   endtask

   task automatic test_reset();
      drive_id(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
      #2;
      checks++; if (val1_forward_sel !== 2'b00) begin errors++; $display("FAIL reset_val1 got %b exp 00", val1_forward_sel); end
      checks++; if (val2_forward_sel !== 2'b00) begin errors++; $display("FAIL reset_val2 got %b exp 00", val2_forward_sel); end
      checks++; if (val3_forward_sel !== 2'b00) begin errors++; $display("FAIL reset_val3 got %b exp 00", val3_forward_sel); end
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", hazard_stall); end
      nop_id();
      @(negedge clk);
      rst_n = 1'b1;
      drain();
   endtask

   task automatic test_mem_forward();
      int st;
      logic [1:0] exp1;
      int exp_st;
      exp1   = FWD ? 2'b01 : 2'b00;
      exp_st = FWD ? 0 : 2;
      drain();
      issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, st);
      checks++; if (st !== 0) begin errors++; $display("FAIL t1_add_stalls got %0d exp 0", st); end
      issue(5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, st);
      checks++; if (st !== exp_st) begin errors++; $display("FAIL t1_sub_stalls got %0d exp %0d", st, exp_st); end
      checks++; if (val1_forward_sel !== exp1) begin errors++; $display("FAIL t1_val1 got %b exp %b", val1_forward_sel, exp1); end
      checks++; if (val2_forward_sel !== 2'b00) begin errors++; $display("FAIL t1_val2 got %b exp 00", val2_forward_sel); end
      checks++; if (val3_forward_sel !== 2'b00) begin errors++; $display("FAIL t1_val3 got %b exp 00", val3_forward_sel); end
   endtask

   task automatic test_wb_forward();
      int st;
      logic [1:0] exp_wb, exp_mem;
      int exp_st1, exp_st2;
      exp_wb  = FWD ? 2'b10 : 2'b00;
      exp_mem = FWD ? 2'b01 : 2'b00;
      exp_st1 = FWD ? 0 : 1;
      exp_st2 = FWD ? 0 : 2;
      drain();
      issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, st);
      issue(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, st);
      issue(5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, st);
      checks++; if (st !== exp_st1) begin errors++; $display("FAIL t2_or_stalls got %0d exp %0d", st, exp_st1); end
      checks++; if (val2_forward_sel !== exp_wb) begin errors++; $display("FAIL t2_val2_wb got %b exp %b", val2_forward_sel, exp_wb); end
      checks++; if (val1_forward_sel !== 2'b00) begin errors++; $display("FAIL t2_val1 got %b exp 00", val1_forward_sel); end
      drain();
      issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, st);
      issue(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, st);
      issue(5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, st);
      checks++; if (st !== exp_st2) begin errors++; $display("FAIL t2_prio_stalls got %0d exp %0d", st, exp_st2); end
      checks++; if (val2_forward_sel !== exp_mem) begin errors++; $display("FAIL t2_val2_prio got %b exp %b", val2_forward_sel, exp_mem); end
      checks++; if (val1_forward_sel !== 2'b00) begin errors++; $display("FAIL t2_prio_val1 got %b exp 00", val1_forward_sel); end
   endtask

   task automatic test_load_use();
      int st;
      logic [1:0] exp1;
      logic exp_stall2;
      exp1       = FWD ? 2'b10 : 2'b00;
      exp_stall2 = FWD ? 1'b0 : 1'b1;
      drain();
      issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, st);
      drive_id(5'd8, 5'd1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
      #1;
      checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL t3_stall_first got %b exp 1", hazard_stall); end
      tick();
      checks++; if (val1_forward_sel !== 2'b00) begin errors++; $display("FAIL t3_bubble_val1 got %b exp 00", val1_forward_sel); end
      checks++; if (val2_forward_sel !== 2'b00) begin errors++; $display("FAIL t3_bubble_val2 got %b exp 00", val2_forward_sel); end
      checks++; if (hazard_stall !== exp_stall2) begin errors++; $display("FAIL t3_stall_second got %b exp %b", hazard_stall, exp_stall2); end
`ifndef FORWARDING_EN
      tick();
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL t3_stall_third got %b exp 0", hazard_stall); end
`endif
      tick();
      nop_id();
      #1;
      checks++; if (val1_forward_sel !== exp1) begin errors++; $display("FAIL t3_val1_wb got %b exp %b", val1_forward_sel, exp1); end
      checks++; if (val2_forward_sel !== 2'b00) begin errors++; $display("FAIL t3_val2 got %b exp 00", val2_forward_sel); end
   endtask

   task automatic test_reg0_and_imm();
      int st;
      drain();
      issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, st);
      issue(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, st);
      checks++; if (st !== 0) begin errors++; $display("FAIL t4_sw_r0_stalls got %0d exp 0", st); end
      checks++; if (val3_forward_sel !== 2'b00) begin errors++; $display("FAIL t4_val3_r0 got %b exp 00", val3_forward_sel); end
      issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, st);
      issue(5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, st);
      checks++; if (st !== 0) begin errors++; $display("FAIL t4_imm_stalls got %0d exp 0", st); end
      checks++; if (val2_forward_sel !== 2'b00) begin errors++; $display("FAIL t4_val2_imm got %b exp 00", val2_forward_sel); end
      checks++; if (val1_forward_sel !== 2'b00) begin errors++; $display("FAIL t4_val1_imm got %b exp 00", val1_forward_sel); end
   endtask

   task automatic test_flush();
      int st;
      drain();
      issue(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, st);
      drive_id(5'd8, 5'd1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL t5_flush_stall got %b exp 0", hazard_stall); end
      tick();
      flush = 1'b0;
      drive_id(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
      #1;
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL t5_after_flush_stall got %b exp 0", hazard_stall); end
      checks++; if (val1_forward_sel !== 2'b00) begin errors++; $display("FAIL t5_bubble_val1 got %b exp 00", val1_forward_sel); end
      tick();
      nop_id();
      #1;
      checks++; if (val1_forward_sel !== 2'b00) begin errors++; $display("FAIL t5_consumer_val1 got %b exp 00", val1_forward_sel); end
   endtask

   task automatic test_reset_midstream();
      int st;
      drain();
      issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, st);
      issue(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, st);
      drive_id(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
      #1;
      checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL t6_pre_reset_stall got %b exp 1", hazard_stall); end
      rst_n = 1'b0;
      #1;
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL t6_reset_stall got %b exp 0", hazard_stall); end
      checks++; if (val1_forward_sel !== 2'b00) begin errors++; $display("FAIL t6_reset_val1 got %b exp 00", val1_forward_sel); end
      checks++; if (val2_forward_sel !== 2'b00) begin errors++; $display("FAIL t6_reset_val2 got %b exp 00", val2_forward_sel); end
      checks++; if (val3_forward_sel !== 2'b00) begin errors++; $display("FAIL t6_reset_val3 got %b exp 00", val3_forward_sel); end
      nop_id();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      issue(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, st);
      checks++; if (st !== 0) begin errors++; $display("FAIL t6_post_stalls got %0d exp 0", st); end
      checks++; if (val1_forward_sel !== 2'b00) begin errors++; $display("FAIL t6_post_val1 got %b exp 00", val1_forward_sel); end
      checks++; if (val2_forward_sel !== 2'b00) begin errors++; $display("FAIL t6_post_val2 got %b exp 00", val2_forward_sel); end
      checks++; if (val3_forward_sel !== 2'b00) begin errors++; $display("FAIL t6_post_val3 got %b exp 00", val3_forward_sel); end
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      nop_id();
      test_reset();
      test_mem_forward();
      test_wb_forward();
      test_load_use();
      test_reg0_and_imm();
      test_flush();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
